minimax_rf_ctrl: RTL
====================

Name: minimax_rf_ctrl

Overview:
Port controller and sequencer in front of minimax_rf, the dual-bank (execution/microcode) 32x32 register file. It multiplexes the RF's single write port and its addrD/rD read path between three sources: the core pipeline, a debug/host access port, and a built-in clear sequencer that zeroes both banks. The RF itself has no reset, so the clear sequencer is required. The core stalls whenever the controller owns the RF.

Parameters:
XLEN, 32, data width; must match minimax_rf.
CLEAR_ON_RESET, 1, 1 = clear sequence starts automatically when reset is released.

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
core_addrS  in  5  core source address
core_addrD  in  5  core destination address
core_new_value  in  XLEN  core writeback data
core_we  in  1  core write enable
core_rS_microcode  in  1  core rS bank select
core_rD_microcode  in  1  core rD bank select
core_stall  out  1  core must hold all core_* inputs and not advance
dbg_req  in  1  debug access request (level)
dbg_we  in  1  1 = write, 0 = read
dbg_bank  in  1  0 = execution, 1 = microcode
dbg_addr  in  5  debug register address
dbg_wdata  in  XLEN  debug write data
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  XLEN  registered read data; valid while dbg_ack = 1, held until the next access
clr_start  in  1  pulse; request a full clear
clr_busy  out  1  clear sequence in progress
clr_done  out  1  one-cycle pulse after the last clear write
rf_addrS, rf_addrD  out  5 each  to RF
rf_new_value  out  XLEN  to RF
rf_we  out  1  to RF
rf_rS_microcode, rf_rD_microcode  out  1 each  to RF
rf_rD  in  XLEN  RF rD output, used to capture debug reads

Behaviour:
- Single clock domain, synchronous active-low reset: clock is clk, reset is rst_n.
- States: IDLE, CLEAR, DBG_ACC, DBG_ACK.
- Reset:
  - State goes to CLEAR if CLEAR_ON_RESET = 1, otherwise IDLE.
  - Clear counter goes to addr 1, bank 0.
  - dbg_ack = 0, dbg_rdata = 0, clr_done = 0.
  - Reset mid-sequence aborts the clear or debug access with no ack or done pulse.
- core_stall = 1 whenever state != IDLE (combinational from state). clr_busy = (state == CLEAR).
- IDLE:
  - All rf_* outputs are combinational pass-through of core_*.
  - Arbitration priority: clr_start > dbg_req > core.
  - clr_start sampled high -> CLEAR next cycle.
  - Otherwise, dbg_req sampled high -> DBG_ACC.
  - The core operation of that same IDLE cycle completes normally.
- CLEAR:
  - Drives rf_we = 1, rf_new_value = 0, rf_addrD = counter, rf_rD_microcode = bank, rf_addrS = 0.
  - Walks addr 1..31 in bank 0, then 1..31 in bank 1: exactly 62 cycles. x0 is never written.
  - clr_done is pulsed in the cycle after the last write; state returns to IDLE.
  - clr_start and dbg_req are ignored during CLEAR; a pending dbg_req is served afterwards.
- DBG_ACC (one cycle):
  - rf_addrD = dbg_addr, rf_rD_microcode = dbg_bank, rf_we = dbg_we, rf_new_value = dbg_wdata.
  - dbg_rdata is registered from rf_rD on this cycle's closing edge. For a write, this is the pre-write value.
  - -> DBG_ACK.
- DBG_ACK:
  - dbg_ack = 1, rf_we = 0, core pass-through is not enabled; -> IDLE.
  - The requester must drop dbg_req in the ack cycle.
  - Latency: dbg_ack is asserted 2 cycles after dbg_req is first sampled in IDLE.
- Fairness: after DBG_ACK the controller spends at least one cycle in IDLE with core_stall = 0 before accepting another debug request. A held-high dbg_req yields a 3-cycle period with one core slot.
- Debug write to addr 0 is acked but has no effect (the RF gates it); a read of addr 0 returns 0 after a clear.
- A debug access and a core write never occur in the same cycle: rf_we is owned by exactly one source per cycle.

Decomposition:
- Package minimax_rf_pkg holds:
  - the state encoding (IDLE, CLEAR, DBG_ACC, DBG_ACK);
  - RF_ADDR_W = 5 and CLEAR_LEN = 62;
  - bank encodings BANK_EXEC = 0 and BANK_UCODE = 1.
- Optional sub-module minimax_rf_clear_seq: the addr/bank counter that emits last-write and done signals.
- The top level instantiates the controller only; minimax_rf is instantiated by the parent.

Test Plan:
- CLEAR_ON_RESET = 1, release rst_n -> core_stall and clr_busy high for exactly 62 cycles; 62 writes of 0 covering bank0/1 addr 1..31; clr_done pulses once; no write to addr 0.
- In IDLE, core_we = 1, addrD = 5, value 0xDEADBEEF, bank 0 -> rf_* mirrors core the same cycle; a debug read of bank 0 addr 5 then returns 0xDEADBEEF with dbg_ack 2 cycles after req.
- Debug write bank 1 addr 7 = 0x12345678, then a core read via rS_microcode = 1, addrS = 7 -> 0x12345678; bank 0 addr 7 unchanged (0).
- clr_start and dbg_req asserted in the same IDLE cycle -> CLEAR runs first; the debug access completes after clr_done, acked 2 cycles after the return to IDLE.
- dbg_req held high for 10 cycles with re-requests -> the pattern DBG_ACC, DBG_ACK, IDLE repeats and core_stall = 0 in every third cycle.
- rst_n asserted in cycle 20 of CLEAR -> no clr_done, rf_we stops; the clear restarts from bank 0 addr 1 after release.

Source files
------------

// File: rtl/minimax_rf_pkg.sv
// minimax_rf_pkg
// Shared definitions for the minimax_rf port controller: controller state
// encoding, register-file geometry and bank encodings.
// No ports (package).
package minimax_rf_pkg;

  localparam int RF_ADDR_W = 5;
  // Registers 1..31 in each of the two banks; x0 is never written.
  localparam int CLEAR_LEN = 62;

  localparam logic BANK_EXEC  = 1'b0;
  localparam logic BANK_UCODE = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    DBG_ACC = 2'd2,
    DBG_ACK = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/minimax_rf_clear_seq.sv
// minimax_rf_clear_seq
// Address/bank walker for the register-file clear sequence. Steps through
// addr 1..31 of the execution bank, then 1..31 of the microcode bank.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   en         : advance one position this cycle (controller is in CLEAR)
//   addr, bank : current write position
//   last       : this cycle is the final clear write
//   done       : one-cycle pulse in the cycle after the final write
module minimax_rf_clear_seq
  import minimax_rf_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  output logic [RF_ADDR_W-1:0] addr,
  output logic                 bank,
  output logic                 last,
  output logic                 done
);

  assign last = en && (addr == '1) && (bank == BANK_UCODE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr <= RF_ADDR_W'(1);
      bank <= BANK_EXEC;
      done <= 1'b0;
    end else begin
      done <= last;
      if (en) begin
        // Wrapping from 31 skips x0 and flips the bank; after the microcode
        // bank this lands back on exec/1, ready for the next clear.
        if (addr == '1) begin
          addr <= RF_ADDR_W'(1);
          bank <= ~bank;
        end else begin
          addr <= addr + RF_ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/minimax_rf_ctrl.sv
// minimax_rf_ctrl
// Port controller in front of minimax_rf. Multiplexes the RF write port and
// rD read path between the core pipeline, a debug access port and the
// built-in clear sequencer. The core is stalled whenever it does not own the RF.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   core_*                : core pipeline RF request; core_stall holds it off
//   dbg_req/we/bank/addr/wdata, dbg_ack, dbg_rdata : debug access port
//   clr_start, clr_busy, clr_done                  : clear sequencer control
//   rf_*                  : connections to minimax_rf
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | core owns the RF, arbitrate clr_start > dbg_req
// CLEAR   | sequencer writes 0 to bank0/1 addr 1..31, core stalled
// DBG_ACC | debug read/write applied to the RF, rD captured at cycle end
// DBG_ACK | dbg_ack pulse, RF idle, always followed by an IDLE core slot
module minimax_rf_ctrl
  import minimax_rf_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [RF_ADDR_W-1:0] core_addrS,
  input  logic [RF_ADDR_W-1:0] core_addrD,
  input  logic [XLEN-1:0]      core_new_value,
  input  logic                 core_we,
  input  logic                 core_rS_microcode,
  input  logic                 core_rD_microcode,
  output logic                 core_stall,
  input  logic                 dbg_req,
  input  logic                 dbg_we,
  input  logic                 dbg_bank,
  input  logic [RF_ADDR_W-1:0] dbg_addr,
  input  logic [XLEN-1:0]      dbg_wdata,
  output logic                 dbg_ack,
  output logic [XLEN-1:0]      dbg_rdata,
  input  logic                 clr_start,
  output logic                 clr_busy,
  output logic                 clr_done,
  output logic [RF_ADDR_W-1:0] rf_addrS,
  output logic [RF_ADDR_W-1:0] rf_addrD,
  output logic [XLEN-1:0]      rf_new_value,
  output logic                 rf_we,
  output logic                 rf_rS_microcode,
  output logic                 rf_rD_microcode,
  input  logic [XLEN-1:0]      rf_rD
);

  ctrl_state_e state, state_nxt;

  logic [RF_ADDR_W-1:0] seq_addr;
  logic                 seq_bank;
  logic                 seq_last;
  logic                 seq_done;
  logic                 we_int;

  minimax_rf_clear_seq u_clear_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == CLEAR),
    .addr  (seq_addr),
    .bank  (seq_bank),
    .last  (seq_last),
    .done  (seq_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR_ON_RESET ? CLEAR : IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_nxt = CLEAR;
        end else if (dbg_req) begin
          state_nxt = DBG_ACC;
        end
      end
      CLEAR:   if (seq_last) state_nxt = IDLE;
      DBG_ACC: state_nxt = DBG_ACK;
      DBG_ACK: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rf_addrS        = '0;
    rf_addrD        = '0;
    rf_new_value    = '0;
    we_int          = 1'b0;
    rf_rS_microcode = BANK_EXEC;
    rf_rD_microcode = BANK_EXEC;
    case (state)
      IDLE: begin
        rf_addrS        = core_addrS;
        rf_addrD        = core_addrD;
        rf_new_value    = core_new_value;
        we_int          = core_we;
        rf_rS_microcode = core_rS_microcode;
        rf_rD_microcode = core_rD_microcode;
      end
      CLEAR: begin
        rf_addrD        = seq_addr;
        rf_rD_microcode = seq_bank;
        we_int          = 1'b1;
      end
      DBG_ACC: begin
        rf_addrD        = dbg_addr;
        rf_rD_microcode = dbg_bank;
        rf_new_value    = dbg_wdata;
        we_int          = dbg_we;
      end
      DBG_ACK: begin
        rf_addrD        = dbg_addr;
        rf_rD_microcode = dbg_bank;
      end
      default: ;
    endcase
  end

  // The state register parks in CLEAR while reset is held; masking here keeps
  // an aborted clear or debug access from landing a write on the reset edge.
  assign rf_we = we_int & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dbg_rdata <= '0;
    end else if (state == DBG_ACC) begin
      dbg_rdata <= rf_rD;
    end
  end

  assign core_stall = (state != IDLE);
  assign clr_busy   = (state == CLEAR);
  assign dbg_ack    = (state == DBG_ACK);
  assign clr_done   = seq_done;

endmodule
